// File: rtl/dbus_responder_pkg.sv
// Shared data-bus definitions for the memory-stage responder: bus widths,
// the request/response structs and the wait-counter width.
package dbus_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [1:0]        msize_t;
  typedef logic [STRB_W-1:0] strobe_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_if.sv
// Request/response bundle between the memory stage (master) and the
// responder (slave).
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder_mem_array.sv
// Word-indexed backing store: byte-enable write on the clock edge,
// combinational read. Contents are deliberately never reset.
module dbus_mem_array
  import dbus_responder_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic                     we,
  input  strobe_t                  strobe,
  input  word_t                    wdata,
  output word_t                    rdata
);

  word_t mem [WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we && strobe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder: accepts one request at a time, waits
// LATENCY cycles, then returns the addressed word and commits any write.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             resetn,
  dbus_responder_if.slave  bus
);

  localparam int IDXW = $clog2(MEM_WORDS);

  // state | meaning
  // IDLE  | addr_ok mirrors dreq.valid; a valid request is accepted here
  // WAIT  | latency down-counter running, requests ignored
  // RESP  | data_ok high for one cycle, write commits at the closing edge
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [IDXW-1:0]  latIdx;
  strobe_t          latStrobe;
  word_t            latData;
  word_t            rdWord;
  logic             accept;
  logic             dataOk;
  logic             unusedReqBits;

  assign accept = (state == IDLE) && bus.dreq.valid;

  // Only the word index is kept; byte offset and size never affect storage.
  assign unusedReqBits = ^{bus.dreq.size, bus.dreq.addr[1:0], bus.dreq.addr[ADDR_W-1:IDXW+2]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      latIdx    <= '0;
      latStrobe <= '0;
      latData   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        latIdx    <= bus.dreq.addr[2 +: IDXW];
        latStrobe <= bus.dreq.strobe;
        latData   <= bus.dreq.data;
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
          end else begin
            stateNext = WAIT;
            cntNext   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cntNext = cnt - 1'b1;
        if (cnt == CNT_W'(1)) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    dataOk = (state == RESP);
    bus.dresp         = '0;
    bus.dresp.addr_ok = (state == IDLE) && bus.dreq.valid && resetn;
    bus.dresp.data_ok = dataOk;
    bus.dresp.data    = dataOk ? rdWord : '0;
  end

  dbus_mem_array #(
    .WORDS (MEM_WORDS)
  ) u_mem (
    .clk    (clk),
    .idx    (latIdx),
    .we     (dataOk && (latStrobe != '0)),
    .strobe (latStrobe),
    .wdata  (latData),
    .rdata  (rdWord)
  );

endmodule

// File: tb/tb_dbus_responder.sv
// Randomised bench for dbus_responder: two instances (LATENCY 2 and 1)
// checked against a word-array reference model.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dbus_responder_if bus2 ();
  dbus_responder_if bus1 ();

  dbus_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));
  dbus_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  int total = 0;
  int bad = 0;
  word_t ref2 [1024];
  word_t ref1 [1024];

  function automatic int idxOf(addr_t a);
    return int'((a / 4) % 1024);
  endfunction

  function automatic word_t merge(word_t old, strobe_t s, word_t d);
    word_t r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r = (r & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
    return r;
  endfunction

  // Drives one request on bus2 and reports what the DUT did; no checking here.
  task automatic runTxn(input addr_t a, input strobe_t s, input word_t d, input bit scramble,
                        output bit aok, output int lat, output word_t rd, output bit quiet);
    @(posedge clk); #1;
    bus2.dreq.valid  = 1'b1;
    bus2.dreq.addr   = a;
    bus2.dreq.size   = msize_t'($urandom);
    bus2.dreq.strobe = s;
    bus2.dreq.data   = d;
    @(negedge clk);
    aok = bus2.dresp.addr_ok;
    @(posedge clk); #1;
    bus2.dreq.valid = 1'b0;
    if (scramble) begin
      bus2.dreq.addr   = ~a;
      bus2.dreq.data   = ~d;
      bus2.dreq.strobe = ~s;
    end
    lat = -1; rd = '0; quiet = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus2.dresp.data_ok === 1'b1) begin
        lat = n; rd = bus2.dresp.data;
        break;
      end
      if (bus2.dresp.data !== '0 || bus2.dresp.addr_ok !== 1'b0) quiet = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus2.dreq = '0; bus1.dreq = '0;
    bus2.dreq.valid = 1'b1; bus2.dreq.addr = 32'h100;
    bus1.dreq.valid = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus2.dresp !== '0) begin bad++; $display("FAIL reset_resp2: got %h want 0", bus2.dresp); end
    total++; if (bus1.dresp !== '0) begin bad++; $display("FAIL reset_resp1: got %h want 0", bus1.dresp); end
    bus2.dreq = '0; bus1.dreq = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    bit aok, quiet; int lat; word_t rd;
    runTxn(32'h100, 4'hF, 32'hDEADBEEF, 1'b0, aok, lat, rd, quiet);
    total++; if (aok !== 1'b1) begin bad++; $display("FAIL basic_addr_ok: got %b want 1", aok); end
    total++; if (lat != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    total++; if (!quiet) begin bad++; $display("FAIL basic_quiet: resp not zero before data_ok"); end
    ref2[idxOf(32'h100)] = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (bus2.dresp.data_ok !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got %b want 0", bus2.dresp.data_ok); end
    runTxn(32'h100, 4'h0, 32'h0, 1'b0, aok, lat, rd, quiet);
    total++; if (lat != 2) begin bad++; $display("FAIL basic_rd_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_write();
    bit aok, quiet; int lat; word_t rd;
    runTxn(32'h101, 4'b0010, 32'h0000AA00, 1'b0, aok, lat, rd, quiet);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL byte_prewrite: got %h want deadbeef", rd); end
    ref2[idxOf(32'h101)] = merge(ref2[idxOf(32'h101)], 4'b0010, 32'h0000AA00);
    runTxn(32'h100, 4'h0, 32'h0, 1'b0, aok, lat, rd, quiet);
    total++; if (rd !== 32'hDEADAAEF) begin bad++; $display("FAIL byte_readback: got %h want deadaaef", rd); end
  endtask

  task automatic test_wrap();
    bit aok, quiet; int lat; word_t rd;
    runTxn(32'h1000, 4'hF, 32'h12345678, 1'b0, aok, lat, rd, quiet);
    ref2[idxOf(32'h1000)] = 32'h12345678;
    runTxn(32'h0000, 4'h0, 32'h0, 1'b0, aok, lat, rd, quiet);
    total++; if (rd !== ref2[0]) begin bad++; $display("FAIL wrap_read: got %h want %h", rd, ref2[0]); end
  endtask

  task automatic test_latched();
    bit aok, quiet; int lat; word_t rd;
    runTxn(32'h140, 4'hF, 32'hCAFEF00D, 1'b1, aok, lat, rd, quiet);
    ref2[idxOf(32'h140)] = 32'hCAFEF00D;
    total++; if (lat != 2) begin bad++; $display("FAIL latched_latency: got %0d want 2", lat); end
    runTxn(32'h140, 4'h0, 32'h0, 1'b1, aok, lat, rd, quiet);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL latched_data: got %h want cafef00d", rd); end
  endtask

  task automatic test_lat1_stream();
    int accepts = 0, oks = 0;
    addr_t a; word_t d;
    for (int k = 0; k < 8; k++) begin
      a = addr_t'(((k % 4) + 40) * 4);
      @(posedge clk); #1;
      bus1.dreq.valid  = 1'b1;
      bus1.dreq.addr   = a;
      bus1.dreq.size   = 2'd2;
      d = $urandom;
      bus1.dreq.strobe = (k < 4) ? 4'hF : 4'h0;
      bus1.dreq.data   = d;
      @(negedge clk);
      if (bus1.dresp.addr_ok === 1'b1) accepts++;
      total++; if (bus1.dresp.addr_ok !== 1'b1 || bus1.dresp.data_ok !== 1'b0)
        begin bad++; $display("FAIL lat1_accept_cycle k=%0d: got aok=%b dok=%b want 1/0", k, bus1.dresp.addr_ok, bus1.dresp.data_ok); end
      @(negedge clk);
      if (bus1.dresp.data_ok === 1'b1) oks++;
      total++; if (bus1.dresp.addr_ok !== 1'b0 || bus1.dresp.data_ok !== 1'b1)
        begin bad++; $display("FAIL lat1_resp_cycle k=%0d: got aok=%b dok=%b want 0/1", k, bus1.dresp.addr_ok, bus1.dresp.data_ok); end
      if (k < 4) ref1[idxOf(a)] = d;
      else begin
        total++; if (bus1.dresp.data !== ref1[idxOf(a)])
          begin bad++; $display("FAIL lat1_read k=%0d: got %h want %h", k, bus1.dresp.data, ref1[idxOf(a)]); end
      end
    end
    @(posedge clk); #1;
    bus1.dreq = '0;
    total++; if (accepts != 8 || oks != 8) begin bad++; $display("FAIL lat1_counts: got %0d/%0d want 8/8", accepts, oks); end
  endtask

  task automatic test_random();
    bit aok, quiet, scr; int lat, ix; word_t rd, d; addr_t a; strobe_t s;
    for (int i = 16; i < 24; i++) begin
      d = $urandom;
      runTxn(addr_t'(i * 4), 4'hF, d, 1'b0, aok, lat, rd, quiet);
      ref2[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      ix = 16 + int'($urandom_range(0, 7));
      a = addr_t'((ix + 1024 * int'($urandom_range(0, 3))) * 4 + int'($urandom_range(0, 3)));
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : strobe_t'($urandom);
      d = $urandom;
      scr = 1'($urandom);
      runTxn(a, s, d, scr, aok, lat, rd, quiet);
      total++; if (aok !== 1'b1 || lat != 2 || !quiet)
        begin bad++; $display("FAIL rand_timing n=%0d: got aok=%b lat=%0d quiet=%b want 1/2/1", n, aok, lat, quiet); end
      total++; if (rd !== ref2[ix]) begin bad++; $display("FAIL rand_data n=%0d: got %h want %h", n, rd, ref2[ix]); end
      ref2[ix] = merge(ref2[ix], s, d);
    end
  endtask

  task automatic test_mid_reset();
    bit aok, quiet; int lat; word_t rd;
    bit sawOk = 1'b0;
    runTxn(32'h200, 4'hF, 32'hA5A5_0001, 1'b0, aok, lat, rd, quiet);
    ref2[idxOf(32'h200)] = 32'hA5A5_0001;
    @(posedge clk); #1;
    bus2.dreq.valid = 1'b1; bus2.dreq.addr = 32'h200; bus2.dreq.strobe = 4'hF; bus2.dreq.data = 32'h5A5A_FFFF;
    @(negedge clk);
    total++; if (bus2.dresp.addr_ok !== 1'b1) begin bad++; $display("FAIL midrst_accept: got %b want 1", bus2.dresp.addr_ok); end
    @(posedge clk); #1;
    resetn = 1'b0;
    bus2.dreq.valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus2.dresp.data_ok !== 1'b0) sawOk = 1'b1;
    end
    total++; if (sawOk) begin bad++; $display("FAIL midrst_no_data_ok: got data_ok during reset want none"); end
    bus2.dreq.valid = 1'b1; bus2.dreq.addr = 32'h200; bus2.dreq.strobe = 4'h0; bus2.dreq.data = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (bus2.dresp.addr_ok !== 1'b1) begin bad++; $display("FAIL midrst_release_aok: got %b want 1", bus2.dresp.addr_ok); end
    @(posedge clk); #1;
    bus2.dreq.valid = 1'b0;
    lat = -1; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus2.dresp.data_ok === 1'b1) begin lat = n; rd = bus2.dresp.data; break; end
    end
    total++; if (lat != 2) begin bad++; $display("FAIL midrst_latency: got %0d want 2", lat); end
    total++; if (rd !== ref2[idxOf(32'h200)]) begin bad++; $display("FAIL midrst_old_data: got %h want %h", rd, ref2[idxOf(32'h200)]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ref2[i] = '0; ref1[i] = '0; end
    test_reset();
    test_basic();
    test_byte_write();
    test_wrap();
    test_latched();
    test_lat1_stream();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, power of two; word depth of the backing array.
REQ-002 SHALL have parameter LATENCY, default 2, range 1..15; cycles from acceptance to data_ok.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port dreq  input  dbus_req_t  request from the memory stage: valid, addr, size, strobe[3:0], data.
REQ-006 SHALL have port dresp  output  dbus_resp_t  response: addr_ok, data_ok, data.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-008 SHALL, in IDLE, drive dresp.addr_ok = dreq.valid combinationally; the request is accepted in that cycle.
REQ-009 SHALL, on acceptance, latch addr, strobe and data, then go to RESP if LATENCY==1, else to WAIT with counter = LATENCY-1.
REQ-010 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it reaches 1.
REQ-011 SHALL, in RESP, assert data_ok for exactly one cycle, then return to IDLE.
REQ-012 SHALL hold addr_ok low in WAIT and RESP; earliest next acceptance is the cycle after RESP.
REQ-013 SHALL treat strobe==4'b0000 as a read; data = full word at index addr[2 +: log2(MEM_WORDS)], unshifted; byte/half extraction is the requester's job.
REQ-014 SHALL treat strobe!=0 as a write; only bytes with strobe bit set are updated, at the RESP-cycle edge; a write's dresp.data is the pre-write word.
REQ-015 SHALL ignore addr[1:0] and size for indexing; size is not checked against strobe.
REQ-016 SHALL wrap out-of-range addresses modulo MEM_WORDS; no error response exists.
REQ-017 SHALL drive dresp.data = '0 whenever data_ok is low.
REQ-018 SHALL ignore changes on dreq while in WAIT or RESP; latched values are used.
REQ-019 SHALL, for simultaneous RESP and valid request, not accept (addr_ok=0); the requester holds valid.

Reset
REQ-020 SHALL, while resetn low, force state IDLE, counter 0, latched request '0; data_ok and dresp.data 0; addr_ok follows REQ-008 after release only.
REQ-021 SHALL drop any pending request on mid-operation reset; no write commits, no data_ok is produced.
REQ-022 SHALL NOT clear array contents on reset.

Structure
REQ-023 SHALL take dbus_req_t, dbus_resp_t, addr_t, word_t, msize_t and strobe width from the shared defs package; FSM state enum stays local.
REQ-024 SHALL place the storage in one sub-module dbus_mem_array: word-indexed, synchronous byte-enable write, combinational read.

Verification
REQ-025 LATENCY=2: write addr 0x100, strobe 4'hF, data 0xDEADBEEF -> addr_ok same cycle, data_ok 2 cycles later; then read 0x100 -> data 0xDEADBEEF.
REQ-026 Byte write addr 0x101, strobe 4'b0010, data 0x0000AA00 over 0xDEADBEEF -> subsequent read returns 0xDEADAAEF.
REQ-027 LATENCY=1, valid held high continuously with reads -> addr_ok every other cycle (accept, RESP, accept...), one data_ok per acceptance.
REQ-028 MEM_WORDS=1024: write 0x1000 data 0x12345678 -> read 0x0000 returns 0x12345678 (wrap).
REQ-029 Reset asserted in WAIT of a write to 0x200 -> no data_ok; read 0x200 afterwards returns old contents; addr_ok available first cycle after release.
REQ-030 dreq.addr/data changed during WAIT -> response and write use originally accepted values.
